// File: rtl/crc16_tx_framer.sv
// ---------------------------------------------------------------------------
// crc16_tx_framer
//
// Transmit-side Modbus RTU framer. Payload bytes from the response builder
// are forwarded to the UART TX path through a single output register and, in
// the same cycle, folded into an external CRC-16 engine (init 0xFFFF,
// reflected, poly 0xA001). After the last payload byte the framer appends the
// CRC low byte, then the high byte (flagged with m_last_o), and clears the
// engine for the next frame. Frames longer than MAX_PAYLOAD are truncated:
// the excess bytes are swallowed, len_err_o pulses once, and the frame is
// still closed with the CRC of the bytes that were actually sent.
//
// Parameters:
//   MAX_PAYLOAD  maximum payload bytes per frame (1..65535)
//   CNT_W        payload counter width, 2**CNT_W > MAX_PAYLOAD
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid_i/s_ready_o payload byte handshake
//   s_data_i, s_last_i  payload byte and end-of-frame marker
//   m_valid_o/m_ready_i output byte handshake (UART TX side)
//   m_data_o, m_last_o  output byte, m_last_o marks the CRC high byte
//   crc_en_o            fold crc_data_o into the engine this cycle
//   crc_clr_o           synchronous clear of the engine to 0xFFFF
//   crc_data_o          byte to fold (always s_data_i)
//   crc_in_i            current CRC value from the engine
//   len_err_o           one-cycle pulse when a frame is truncated
//
// Optional build macro CRC_TX_STATS_EN adds:
//   frame_cnt_o [15:0]  frames closed (wrapping)
//   trunc_cnt_o [7:0]   truncated frames (saturating at 0xFF)
// ---------------------------------------------------------------------------
module crc16_tx_framer #(
    parameter int unsigned MAX_PAYLOAD = 254,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [7:0]  m_data_o,
    output logic        m_last_o,
    output logic        crc_en_o,
    output logic        crc_clr_o,
    output logic [7:0]  crc_data_o,
    input  logic [15:0] crc_in_i,
    output logic        len_err_o
`ifdef CRC_TX_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [7:0]  trunc_cnt_o
`endif
);

    // Counter value of the last byte that may still be forwarded.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PAYLOAD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CRC_LO  = 3'd2,
        ST_CRC_HI  = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               m_valid_q, m_valid_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               len_err_q, len_err_d;

    logic               loadable_s;
    logic               s_ready_s;
    logic               crc_en_s;
    logic               crc_clr_s;

    // The output register can take a new byte when empty or being drained.
    assign loadable_s = !m_valid_q || m_ready_i;

    // State register and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            len_err_q <= len_err_d;
        end
    end

    // Next-state, output-register load and CRC engine sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        len_err_d = 1'b0;
        s_ready_s = 1'b0;
        crc_en_s  = 1'b0;
        crc_clr_s = 1'b0;

        // A byte taken downstream empties the register unless reloaded below.
        if (m_ready_i) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_IDLE, ST_PAYLOAD: begin
                s_ready_s = loadable_s;
                if (s_valid_i && loadable_s) begin
                    m_data_d  = s_data_i;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    crc_en_s  = 1'b1;
                    if (s_last_i) begin
                        state_d = ST_CRC_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_IDX) begin
                        // Byte still forwarded; the rest of the frame is dropped.
                        state_d   = ST_DROP;
                        cnt_d     = '0;
                        len_err_d = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_DROP: begin
                // Excess bytes are accepted and discarded, not folded.
                s_ready_s = 1'b1;
                if (s_valid_i && s_last_i) begin
                    state_d = ST_CRC_LO;
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_CRC_LO: begin
                // Entered one cycle after the last crc_en, so crc_in_i is final.
                if (loadable_s) begin
                    m_data_d  = crc_in_i[7:0];
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = ST_CRC_HI;
                end else begin
                    state_d = ST_CRC_LO;
                end
            end

            ST_CRC_HI: begin
                if (loadable_s) begin
                    m_data_d  = crc_in_i[15:8];
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    crc_clr_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_CRC_HI;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign s_ready_o  = s_ready_s;
    assign crc_en_o   = crc_en_s;
    assign crc_clr_o  = crc_clr_s;
    assign crc_data_o = s_data_i;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign m_last_o   = m_last_q;
    assign len_err_o  = len_err_q;

`ifdef CRC_TX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  trunc_cnt_q;
    logic        frame_inc_s;

    assign frame_inc_s = (state_q == ST_CRC_HI) && loadable_s;

    // Frame counter wraps; truncation counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'h0000;
            trunc_cnt_q <= 8'h00;
        end else begin
            if (frame_inc_s) begin
                frame_cnt_q <= frame_cnt_q + 16'h0001;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
            if (len_err_q && (trunc_cnt_q != 8'hFF)) begin
                trunc_cnt_q <= trunc_cnt_q + 8'h01;
            end else begin
                trunc_cnt_q <= trunc_cnt_q;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign trunc_cnt_o = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_tx_framer.sv
// ---------------------------------------------------------------------------
// Testbench for crc16_tx_framer. Two instances: dut0 with the default
// MAX_PAYLOAD, dut1 with MAX_PAYLOAD=4 for truncation. Each has its own
// CRC-16/Modbus engine in the bench. A frame-level model turns each sent
// payload into the expected output beats (truncated payload + CRC lo, hi).
// ---------------------------------------------------------------------------
module tb_crc16_tx_framer;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       s_valid, s_ready, s_last, m_valid, m_ready, m_last;
    logic [1:0]       crc_en, crc_clr, len_err;
    logic [1:0][7:0]  s_data, m_data, crc_data;
    logic [1:0][15:0] eng;
    int               max_pl [2];

`ifdef CRC_TX_STATS_EN
    logic [1:0][15:0] frame_cnt;
    logic [1:0][7:0]  trunc_cnt;
`endif

    crc16_tx_framer dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]), .s_last_i(s_last[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0]), .m_last_o(m_last[0]),
        .crc_en_o(crc_en[0]), .crc_clr_o(crc_clr[0]), .crc_data_o(crc_data[0]), .crc_in_i(eng[0]),
        .len_err_o(len_err[0])
`ifdef CRC_TX_STATS_EN
        , .frame_cnt_o(frame_cnt[0]), .trunc_cnt_o(trunc_cnt[0])
`endif
    );

    crc16_tx_framer #(.MAX_PAYLOAD(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]), .s_last_i(s_last[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1]), .m_last_o(m_last[1]),
        .crc_en_o(crc_en[1]), .crc_clr_o(crc_clr[1]), .crc_data_o(crc_data[1]), .crc_in_i(eng[1]),
        .len_err_o(len_err[1])
`ifdef CRC_TX_STATS_EN
        , .frame_cnt_o(frame_cnt[1]), .trunc_cnt_o(trunc_cnt[1])
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 16'hA001;
            else      r = r >> 1;
        end
        return r;
    endfunction

    // External CRC engines, one per instance, reset by the same rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng <= {16'hFFFF, 16'hFFFF};
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (crc_clr[d])     eng[d] <= 16'hFFFF;
                else if (crc_en[d]) eng[d] <= crc_step(eng[d], crc_data[d]);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- frame-level model ----------------
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    task automatic model_push(input int d, input bq_t b);
        int          n;
        logic [15:0] c;
        n = (b.size() > max_pl[d]) ? max_pl[d] : b.size();
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = crc_step(c, b[i]);
            if (d == 0) exp0.push_back({1'b0, b[i]});
            else        exp1.push_back({1'b0, b[i]});
        end
        if (d == 0) begin
            exp0.push_back({1'b0, c[7:0]});
            exp0.push_back({1'b1, c[15:8]});
        end else begin
            exp1.push_back({1'b0, c[7:0]});
            exp1.push_back({1'b1, c[15:8]});
        end
    endtask

    // ---------------- compare process ----------------
    logic [1:0] chk_en   = 2'b11;
    bit         cap_en   = 1'b0;
    logic [8:0] cap0[$];
    int         stamp0[$];
    logic [1:0] prev_clr = 2'b00;
    logic [1:0] prev_len = 2'b00;
    int         clr_cnt [2] = '{0, 0};
    int         len_cnt [2] = '{0, 0};

    task automatic pop_check(input int d);
        logic [8:0] e;
        int         sz;
        sz = (d == 0) ? exp0.size() : exp1.size();
        if (sz == 0) begin
            chk($sformatf("dut%0d_unexpected_beat", d), {23'd0, m_last[d], m_data[d]}, 32'h1FF);
        end else begin
            e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("dut%0d_beat", d), {23'd0, m_last[d], m_data[d]}, {23'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (m_valid[d] && m_ready[d] && chk_en[d]) begin
                    pop_check(d);
                    if (d == 0 && cap_en) begin
                        cap0.push_back({m_last[0], m_data[0]});
                        stamp0.push_back(cyc);
                    end
                end
                chk($sformatf("dut%0d_en_clr_excl", d), {31'd0, crc_en[d] & crc_clr[d]}, 32'd0);
                if (prev_clr[d])
                    chk($sformatf("dut%0d_clr_with_last", d), {31'd0, m_valid[d] & m_last[d]}, 32'd1);
                if (len_err[d] && prev_len[d])
                    chk($sformatf("dut%0d_len_err_width", d), 32'd2, 32'd1);
                if (crc_clr[d]) clr_cnt[d]++;
                if (len_err[d]) len_cnt[d]++;
                prev_clr[d] = crc_clr[d];
                prev_len[d] = len_err[d];
            end
            if (m_valid[0] && !m_ready[0])
                chk("dut0_s_ready_stall", {31'd0, s_ready[0]}, 32'd0);
        end else begin
            prev_clr = 2'b00;
            prev_len = 2'b00;
        end
    end

    // ---------------- downstream ready ----------------
    bit toggle0 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (toggle0) m_ready[0] = ~m_ready[0];
        else         m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
    end

    // ---------------- driver ----------------
    task automatic send(input int d, input bq_t b, input bit push, input bit close);
        int t;
        if (push) model_push(d, b);
        for (int i = 0; i < b.size(); i++) begin
            s_valid[d] = 1'b1;
            s_data[d]  = b[i];
            s_last[d]  = close && (i == b.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready[d]) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                chk($sformatf("dut%0d_accept_timeout", d), 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while (((d == 0) ? exp0.size() : exp1.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("dut%0d_drain", d), (d == 0) ? exp0.size() : exp1.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    bq_t f1, f2, ft, fa, fb, fc, fd, fab;
    logic [8:0] lit[$];

    initial begin
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        max_pl[0] = 254;
        max_pl[1] = 4;
        f1  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        f2  = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        ft  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        fa  = '{8'h11, 8'h22};
        fb  = '{8'h01, 8'h02, 8'h03, 8'h04};
        fc  = '{8'h55};
        fab = '{8'h01, 8'h03, 8'h00};
        lit = '{9'h001, 9'h003, 9'h000, 9'h000, 9'h000, 9'h001, 9'h084, 9'h10A,
                9'h001, 9'h006, 9'h000, 9'h001, 9'h000, 9'h003, 9'h098, 9'h10B};

        s_valid = 2'b00; s_last = 2'b00; s_data = '0; m_ready = 2'b11;
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_rst_m_valid", d), {31'd0, m_valid[d]}, 32'd0);
            chk($sformatf("dut%0d_rst_m_data", d),  {24'd0, m_data[d]},  32'd0);
            chk($sformatf("dut%0d_rst_m_last", d),  {31'd0, m_last[d]},  32'd0);
            chk($sformatf("dut%0d_rst_len_err", d), {31'd0, len_err[d]}, 32'd0);
            chk($sformatf("dut%0d_rst_crc_en", d),  {31'd0, crc_en[d]},  32'd0);
            chk($sformatf("dut%0d_rst_crc_clr", d), {31'd0, crc_clr[d]}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two back-to-back frames at full rate, pinned against literals.
        cap_en = 1'b1;
        send(0, f1, 1'b1, 1'b1);
        send(0, f2, 1'b1, 1'b1);
        drain(0);
        cap_en = 1'b0;
        chk("frames12_beat_count", cap0.size(), 32'd16);
        for (int i = 0; i < 16 && i < cap0.size(); i++)
            chk($sformatf("frames12_literal_%0d", i), {23'd0, cap0[i]}, {23'd0, lit[i]});
        if (stamp0.size() == 16)
            chk("frames12_no_bubble", stamp0[15] - stamp0[0], 32'd15);
        chk("frames12_clr_pulses", clr_cnt[0], 32'd2);

        // Same frame with downstream ready toggling every cycle.
        toggle0 = 1'b1;
        send(0, f1, 1'b1, 1'b1);
        drain(0);
        toggle0 = 1'b0;
        chk("toggle_clr_pulses", clr_cnt[0], 32'd3);

        // Mid-frame reset after the 3rd byte, then a clean frame.
        chk_en[0] = 1'b0;
        send(0, fab, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", {31'd0, m_valid[0]}, 32'd0);
        chk("midrst_m_last",  {31'd0, m_last[0]},  32'd0);
        chk("midrst_s_ready_idle", {31'd0, s_ready[0]}, 32'd1);
        exp0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en[0] = 1'b1;
        @(posedge clk);
        #1;
        send(0, f1, 1'b1, 1'b1);
        drain(0);

        // Truncation on dut1 (MAX_PAYLOAD=4), then exact-limit and short frames.
        send(1, ft, 1'b1, 1'b1);
        send(1, fa, 1'b1, 1'b1);
        send(1, fb, 1'b1, 1'b1);
        send(1, fc, 1'b1, 1'b1);
        drain(1);
        chk("dut1_len_err_pulses", len_cnt[1], 32'd1);
        chk("dut0_len_err_pulses", len_cnt[0], 32'd0);
        chk("dut1_clr_pulses", clr_cnt[1], 32'd4);
`ifdef CRC_TX_STATS_EN
        chk("dut1_frame_cnt", {16'd0, frame_cnt[1]}, 32'd4);
        chk("dut1_trunc_cnt", {24'd0, trunc_cnt[1]}, 32'd1);
        chk("dut0_frame_cnt", {16'd0, frame_cnt[0]}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_tx_framer.md
Name: crc16_tx_framer

Overview:
Transmit-side Modbus RTU framer that sequences an external CRC-16 engine (init 0xFFFF, reflected, poly 0xA001).
- Forwards payload bytes from the frame builder to the UART TX path.
- Feeds each forwarded byte to the CRC engine.
- On the last payload byte, appends the CRC low byte, then the high byte, then clears the engine for the next frame.
- Sits between the response builder and the UART transmitter.

Parameters:
MAX_PAYLOAD, 254, maximum payload bytes per frame (Modbus ADU 256 minus 2 CRC bytes); legal range 1..65535
CNT_W, 16, width of the internal payload byte counter; must satisfy 2^CNT_W > MAX_PAYLOAD

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  payload byte valid
s_ready  out  1  payload byte accepted when s_valid & s_ready
s_data  in  8  payload byte
s_last  in  1  marks final payload byte of frame
m_valid  out  1  output byte valid
m_ready  in  1  downstream (UART TX) accepts when m_valid & m_ready
m_data  out  8  output byte
m_last  out  1  marks CRC high byte (end of frame)
crc_en  out  1  to CRC engine: update with crc_data this cycle
crc_clr  out  1  to CRC engine: synchronous clear to 0xFFFF
crc_data  out  8  to CRC engine: byte to fold (equals s_data)
crc_in  in  16  from CRC engine: current CRC, byte order as transmitted-reversed (low byte sent first)
len_err  out  1  one-cycle pulse: frame truncated at MAX_PAYLOAD

Behaviour:
- Reset: state IDLE, m_valid=0, m_data=0, m_last=0, len_err=0, counter=0. crc_en and crc_clr are combinational and read 0 in reset.
- Output register: a single stage. The register is loadable when !m_valid || m_ready.

FSM states: IDLE, PAYLOAD, CRC_LO, CRC_HI, DROP.
- IDLE/PAYLOAD:
  - s_ready = loadable.
  - On accept: m_data<=s_data, m_valid<=1, m_last<=0, crc_en=1, crc_data=s_data, counter+1. IDLE moves to PAYLOAD on the first byte.
  - Accept with s_last=1: go to CRC_LO, counter<=0.
  - Accept with counter==MAX_PAYLOAD-1 and s_last=0: byte forwarded and CRC'd, len_err pulses next cycle, go to DROP.
- DROP:
  - s_ready=1, bytes discarded, no crc_en.
  - On the accept with s_last=1, go to CRC_LO. The frame is still closed with the CRC of the truncated payload.
- CRC_LO:
  - s_ready=0.
  - When loadable: m_data<=crc_in[7:0], m_valid<=1, m_last<=0, go to CRC_HI.
  - Entry is at least one cycle after the final crc_en, so crc_in is settled.
- CRC_HI:
  - s_ready=0.
  - When loadable: m_data<=crc_in[15:8], m_valid<=1, m_last<=1, crc_clr=1 for that cycle, go to IDLE.
- m_valid drops when m_ready is sampled high and nothing new is loaded.
- Throughput: one byte per clock with m_ready held high. Latency s-accept to m_valid is 1 cycle. There are 2 extra beats per frame, and no bubble between CRC_HI and the next frame's first byte.
- crc_en and crc_clr are never asserted in the same cycle.
- Mid-frame reset: all state returns to reset values. The CRC engine is reset by the same rst_n.
- A zero-length frame is not possible: the first accepted byte always counts as payload.

Optional Feature:
Macro CRC_TX_STATS_EN.
- Defined: adds output port frame_cnt [15:0], reset 0. It increments on the cycle the CRC_HI byte is loaded and wraps 0xFFFF to 0x0000. It also adds output trunc_cnt [7:0], which increments on each len_err and saturates at 0xFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Frame 01 03 00 00 00 01 (s_last on 6th), m_ready=1, engine attached -> m stream 01 03 00 00 00 01 84 0A in 8 consecutive cycles, m_last only on 0A, crc_clr pulse once on the 0A load cycle.
- Same frame, then immediately 01 06 00 01 00 03 -> second frame ends 98 0B. Confirms the clear between frames and no bubble.
- m_ready toggled 1/0 every cycle during the first frame -> identical byte sequence, no byte duplicated or lost, s_ready=0 whenever m_valid & !m_ready.
- MAX_PAYLOAD=4, send 6 bytes AA BB CC DD EE FF (last on FF) -> output AA BB CC DD then CRC of AA BB CC DD (low, high), len_err one pulse, EE/FF consumed and not forwarded.
- Assert rst_n=0 after the 3rd byte of a frame -> m_valid=0 and state IDLE immediately. After release, a fresh 01 03 00 00 00 01 frame yields 84 0A.
- With CRC_TX_STATS_EN: 3 frames plus 1 truncated frame -> frame_cnt=4, trunc_cnt=1.
